// File: rtl/async_fifo_pkg.sv
// Pointer coding helpers shared by the read- and write-side FIFO controllers.
// Functions work on a wide word; callers zero-extend and truncate to their pointer width.
package async_fifo_pkg;

    localparam int PTR_MAX_W = 32;
    localparam int OUT_BUF_DEPTH = 2;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros from zero-extension decode to zeros, so truncating the result is exact.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the read clock domain.
module sync_2ff #(
    parameter int width = 1
) (
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] meta_reg;
    logic [width-1:0] sync_reg;

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO with a 2-entry prefetch output buffer.
// Optional registered fill level: define ASYNC_FIFO_RD_LEVEL_EN.
module async_fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int fifo_data_size = 8,
    parameter int fifo_ptr_size  = 8
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst_n,
    input  logic [fifo_ptr_size:0]    wr_ptr_gray,
    output logic [fifo_ptr_size:0]    rd_ptr_gray,
    output logic [fifo_ptr_size-1:0]  rd_addr,
    input  logic [fifo_data_size-1:0] rd_data,
    output logic [fifo_data_size-1:0] rd_dout,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      rd_empty,
    output logic [fifo_ptr_size:0]    rd_level
);

    localparam int PW = fifo_ptr_size + 1;

    logic [PW-1:0] wr_ptr_gray_sync;
    logic [PW-1:0] rd_ptr_bin_reg, rd_ptr_bin_next;
    logic [PW-1:0] rd_ptr_gray_reg, rd_ptr_gray_next;
    logic          inflight_reg, inflight_next;
    logic [1:0]    count_reg, count_next, occ_after_pop;
    logic [fifo_data_size-1:0] buf_reg  [OUT_BUF_DEPTH];
    logic [fifo_data_size-1:0] buf_next [OUT_BUF_DEPTH];
    logic          mem_empty;
    logic          pop;
    logic          fetch;

    sync_2ff #(
        .width(PW)
    ) u_wr_ptr_sync (
        .rd_clk  (rd_clk),
        .rd_rst_n(rd_rst_n),
        .d       (wr_ptr_gray),
        .q       (wr_ptr_gray_sync)
    );

    assign mem_empty = (wr_ptr_gray_sync == rd_ptr_gray_reg);
    assign pop       = (count_reg != 2'd0) && rd_ready;

    // A fetch returns data one edge later, so the in-flight word reserves a buffer slot.
    always_comb begin
        occ_after_pop    = count_reg - {1'b0, pop};
        fetch            = !mem_empty &&
                           (({1'b0, occ_after_pop} + {2'b00, inflight_reg}) < 3'd2);
        inflight_next    = fetch;
        rd_ptr_bin_next  = rd_ptr_bin_reg;
        if (fetch) begin
            rd_ptr_bin_next = rd_ptr_bin_reg + PW'(1);
        end
        rd_ptr_gray_next = PW'(bin2gray(PTR_MAX_W'(rd_ptr_bin_next)));

        buf_next = buf_reg;
        if (pop) begin
            buf_next[0] = buf_reg[1];
        end
        if (inflight_reg) begin
            buf_next[occ_after_pop[0]] = rd_data;
        end
        count_next = occ_after_pop + {1'b0, inflight_reg};
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            rd_ptr_bin_reg  <= '0;
            rd_ptr_gray_reg <= '0;
            inflight_reg    <= 1'b0;
            count_reg       <= 2'd0;
        end else begin
            rd_ptr_bin_reg  <= rd_ptr_bin_next;
            rd_ptr_gray_reg <= rd_ptr_gray_next;
            inflight_reg    <= inflight_next;
            count_reg       <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < OUT_BUF_DEPTH; gi++) begin : g_out_buf
            always_ff @(posedge rd_clk) begin
                if (!rd_rst_n) begin
                    buf_reg[gi] <= '0;
                end else begin
                    buf_reg[gi] <= buf_next[gi];
                end
            end
        end
    endgenerate

    assign rd_addr     = rd_ptr_bin_reg[fifo_ptr_size-1:0];
    assign rd_ptr_gray = rd_ptr_gray_reg;
    assign rd_dout     = buf_reg[0];
    assign rd_valid    = (count_reg != 2'd0);
    assign rd_empty    = (count_reg == 2'd0);

`ifdef ASYNC_FIFO_RD_LEVEL_EN
    logic [PW-1:0] wr_ptr_bin_sync;
    logic [PW-1:0] level_reg;

    assign wr_ptr_bin_sync = PW'(gray2bin(PTR_MAX_W'(wr_ptr_gray_sync)));

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            level_reg <= '0;
        end else begin
            level_reg <= wr_ptr_bin_sync - rd_ptr_bin_reg;
        end
    end

    assign rd_level = level_reg;
`else
    assign rd_level = '0;
`endif

endmodule
